// File: rtl/sr_frame_scanner.sv
// ---------------------------------------------------------------------------
// sr_frame_scanner
//
// Purpose:
//   Scans an animation stored in a combinational ROM onto a row-multiplexed
//   display. For each row it fetches one column byte from the ROM and hands it
//   to a shift-register serializer. It waits for the serializer to report the
//   byte latched, lights the row for a fixed dwell time, then moves to the
//   next row. Each frame is scanned REPEATS times before the next frame.
//   After the last frame the scanner wraps back to frame 0.
//
// Parameters:
//   FRAME_COUNT  - number of frames held in the ROM
//   ROWS         - rows (ROM bytes) per frame
//   DWELL_CYCLES - clock cycles each row stays lit
//   REPEATS      - full scans of a frame before advancing to the next frame
//   TIMEOUT      - sampled SHIFT cycles allowed before declaring a stuck
//                  serializer
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   reset      - synchronous active-high reset, overrides everything
//   enable     - level; high keeps scanning, low stops after the current row
//   rom_addr   - ROM byte address (frame base + row)
//   rom_data   - ROM byte at rom_addr, valid in the same cycle
//   ld_data    - column byte presented to the serializer
//   ld_reset   - active-high clear/restart for the serializer
//   ld_finish  - serializer reports that the byte has been shifted and latched
//   row_sel    - one-hot row drive, all-zero while blanked
//   row_oe     - high only while a row is lit
//   frame_idx  - current frame number
//   frame_wrap - one-cycle pulse when frame_idx returns to 0
//   error      - sticky serializer-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module sr_frame_scanner #(
  parameter int FRAME_COUNT  = 77,
  parameter int ROWS         = 8,
  parameter int DWELL_CYCLES = 1000,
  parameter int REPEATS      = 50,
  parameter int TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic [15:0]     rom_addr,
  input  logic [7:0]      rom_data,
  output logic [7:0]      ld_data,
  output logic            ld_reset,
  input  logic            ld_finish,
  output logic [ROWS-1:0] row_sel,
  output logic            row_oe,
  output logic [15:0]     frame_idx,
  output logic            frame_wrap,
  output logic            error
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int REP_W   = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam int CNT_MAX = (TIMEOUT > DWELL_CYCLES) ? TIMEOUT : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CLEAR,
    SHIFT,
    DWELL,
    ADVANCE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ROW_W-1:0]  r_row;
  logic [REP_W-1:0]  r_repeat;
  logic [15:0]       r_frameIdx;
  logic [15:0]       r_base;
  logic [7:0]        r_ldData;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_frameWrap;
  logic              r_error;
  logic              w_shiftDone;
  logic              w_shiftTimeout;
  logic              w_dwellDone;
  logic [ROWS-1:0]   w_rowOneHot;

  // The frame base is kept as a running sum of ROWS, so the ROM address is
  // just base + row with no multiplier in the path.
  assign rom_addr    = r_base + 16'(r_row);
  assign ld_data     = r_ldData;
  assign frame_idx   = r_frameIdx;
  assign frame_wrap  = r_frameWrap;
  assign error       = r_error;
  assign w_rowOneHot = ROWS'(1) << r_row;

  // The serializer may still show a stale finish from the previous byte in the
  // first SHIFT cycle, so ld_finish only counts once r_cnt has moved off zero.
  // The timeout therefore fires after TIMEOUT sampled cycles.
  assign w_shiftDone    = (r_cnt != '0) && ld_finish;
  assign w_shiftTimeout = !w_shiftDone && (r_cnt == CNT_W'(TIMEOUT));
  assign w_dwellDone    = (r_cnt == CNT_W'(DWELL_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and Moore outputs. ld_reset is held high everywhere except
  // SHIFT and DWELL, and row_oe is high only in DWELL, so the two can never
  // be asserted together. enable is only looked at in IDLE and ADVANCE,
  // which lets a row that has started always run to completion.
  always_comb begin
    w_nextState = r_state;
    ld_reset    = 1'b1;
    row_oe      = 1'b0;
    row_sel     = '0;
    case (r_state)
      IDLE: begin
        if (enable && !r_error) begin
          w_nextState = FETCH;
        end
      end
      FETCH: begin
        w_nextState = CLEAR;
      end
      CLEAR: begin
        w_nextState = SHIFT;
      end
      SHIFT: begin
        ld_reset = 1'b0;
        if (w_shiftDone) begin
          w_nextState = DWELL;
        end else if (w_shiftTimeout) begin
          w_nextState = IDLE;
        end
      end
      DWELL: begin
        ld_reset = 1'b0;
        row_oe   = 1'b1;
        row_sel  = w_rowOneHot;
        if (w_dwellDone) begin
          w_nextState = ADVANCE;
        end
      end
      ADVANCE: begin
        w_nextState = enable ? FETCH : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: column byte capture, shared SHIFT/DWELL cycle counter,
  // row/repeat/frame bookkeeping and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_repeat    <= '0;
      r_frameIdx  <= '0;
      r_base      <= '0;
      r_ldData    <= '0;
      r_cnt       <= '0;
      r_frameWrap <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_frameWrap <= 1'b0;
      case (r_state)
        FETCH: begin
          r_ldData <= rom_data;
        end
        CLEAR: begin
          r_cnt <= '0;
        end
        SHIFT: begin
          if (w_shiftDone) begin
            r_cnt <= '0;
          end else if (w_shiftTimeout) begin
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DWELL: begin
          r_cnt <= r_cnt + 1'b1;
        end
        ADVANCE: begin
          if (r_row == ROW_W'(ROWS - 1)) begin
            r_row <= '0;
            if (r_repeat == REP_W'(REPEATS - 1)) begin
              r_repeat <= '0;
              if (r_frameIdx == 16'(FRAME_COUNT - 1)) begin
                r_frameIdx  <= '0;
                r_base      <= '0;
                r_frameWrap <= 1'b1;
              end else begin
                r_frameIdx <= r_frameIdx + 16'd1;
                r_base     <= r_base + 16'(ROWS);
              end
            end else begin
              r_repeat <= r_repeat + 1'b1;
            end
          end else begin
            r_row <= r_row + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/sr_frame_scanner.md
SR_FRAME_SCANNER -- requirements
Module: sr_frame_scanner

Interface
REQ-001 SHALL provide parameter FRAME_COUNT, default 77, number of frames in ROM; last frame index is FRAME_COUNT-1.
REQ-002 SHALL provide parameter ROWS, default 8, rows (ROM bytes) per frame.
REQ-003 SHALL provide parameter DWELL_CYCLES, default 1000, clk cycles each row stays lit.
REQ-004 SHALL provide parameter REPEATS, default 50, full-row scans per frame before advancing.
REQ-005 SHALL provide parameter TIMEOUT, default 64, max clk cycles to wait for ld_finish.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  level; high = scan, low = stop after current row.
REQ-009 rom_addr  output  16  ROM byte address; ROM read is combinational.
REQ-010 rom_data  input  8  ROM byte at rom_addr, valid in same cycle.
REQ-011 ld_data  output  8  column byte to serializer; stable from FETCH until the next FETCH.
REQ-012 ld_reset  output  1  active-high clear/restart to serializer.
REQ-013 ld_finish  input  1  level from serializer; high = byte shifted and latched.
REQ-014 row_sel  output  ROWS  one-hot row drive; all-zero when blanked.
REQ-015 row_oe  output  1  high only while a row is lit (DWELL).
REQ-016 frame_idx  output  16  current frame number.
REQ-017 frame_wrap  output  1  one-cycle pulse when frame_idx wraps to 0.
REQ-018 error  output  1  sticky; set on serializer timeout.

Function
REQ-019 SHALL implement states IDLE, FETCH, CLEAR, SHIFT, DWELL, ADVANCE.
REQ-020 IDLE: ld_reset=1, row_oe=0, row_sel=0; go to FETCH when enable=1 and error=0.
REQ-021 rom_addr SHALL equal base+row, base = frame_idx*ROWS kept as accumulator (add ROWS per frame, no multiplier).
REQ-022 FETCH (1 cycle): register rom_data into ld_data; ld_reset=1; next CLEAR.
REQ-023 CLEAR (1 cycle): ld_reset=1; row_oe=0; next SHIFT.
REQ-024 SHIFT: ld_reset=0; ld_finish ignored in first SHIFT cycle, sampled from second onward; on ld_finish=1 go to DWELL.
REQ-025 SHIFT timeout: after TIMEOUT cycles without ld_finish, set error, go to IDLE.
REQ-026 DWELL: row_sel=one-hot(row), row_oe=1, ld_reset=0, exactly DWELL_CYCLES cycles, then ADVANCE.
REQ-027 ADVANCE (1 cycle, blanked): row+1; at row=ROWS-1 row->0 and repeat+1; at repeat=REPEATS-1 repeat->0 and frame advances.
REQ-028 Frame advance: frame_idx=FRAME_COUNT-1 -> frame_idx=0, base=0, frame_wrap=1 for that cycle; else frame_idx+1, base+ROWS.
REQ-029 After ADVANCE: enable=1 -> FETCH; enable=0 -> IDLE with row/repeat/frame retained.
REQ-030 enable falling mid-row SHALL NOT truncate SHIFT or DWELL.
REQ-031 Row-to-row latency with ld_finish N cycles after ld_reset falls: FETCH+CLEAR+N+DWELL_CYCLES+ADVANCE.
REQ-032 row_oe and ld_reset SHALL never both be 1.

Reset
REQ-033 On reset=1: state=IDLE, row=0, repeat=0, frame_idx=0, base=0, rom_addr=0, ld_data=0, ld_reset=1, row_sel=0, row_oe=0, frame_wrap=0, error=0.
REQ-034 reset in any state, including mid-SHIFT or DWELL, SHALL take effect next edge and override enable.
REQ-035 error SHALL clear only by reset.

Verification (ROWS=8, DWELL_CYCLES=4, REPEATS=2, FRAME_COUNT=3, TIMEOUT=16; serializer model raises ld_finish 17 cycles after ld_reset falls; ROM byte = address)
REQ-036 Reset then enable=1 -> rom_addr=0, ld_data=0x00, row_sel=0x01 lit 4 cycles, then rom_addr=1, row_sel=0x02.
REQ-037 Run 16 rows -> frame_idx=1, rom_addr=8, ld_data=0x08; rows 0-7 of frame 0 each shown twice.
REQ-038 Run 48 rows -> frame_wrap pulses once, frame_idx=0, rom_addr=0.
REQ-039 Model never raises ld_finish -> error=1 after 16 SHIFT cycles, IDLE, row_oe=0; reset clears error.
REQ-040 enable=0 during DWELL of row 3 -> row finishes, IDLE with row=4; enable=1 resumes at rom_addr=4.
REQ-041 reset asserted mid-SHIFT -> next cycle all outputs at REQ-033 values; ld_reset=1.
